// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: Decode/Execute/Memory status in,
// stall/flush/multicycle control and performance counters out.
interface hazard_ctrl_if;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  RdE;
  logic        MemReadE;
  logic        PCSrcE;
  logic        MulDivE;
  logic        MulDivDone;
  logic        DMemReadyM;
  logic        CountClr;

  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        StallM;
  logic        FlushD;
  logic        FlushE;
  logic        FlushW;
  logic        MulDivStart;
  logic        MulDivErr;
  logic [1:0]  CtrlState;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;

  modport master (
    output Rs1D, Rs2D, RdE, MemReadE, PCSrcE, MulDivE, MulDivDone, DMemReadyM, CountClr,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           MulDivStart, MulDivErr, CtrlState, StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, RdE, MemReadE, PCSrcE, MulDivE, MulDivDone, DMemReadyM, CountClr,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           MulDivStart, MulDivErr, CtrlState, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, multicycle
// mul/div wait with watchdog, memory-wait freeze, and stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 40
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MD_WAIT  = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam logic [5:0] WD_LAST = 6'(MD_TIMEOUT - 1);

  state_t      state, state_nxt;
  state_t      ret_state, ret_nxt;
  logic        done_pending, pending_nxt;
  logic [5:0]  wd_cnt, wd_nxt;
  logic        md_err, err_set;
  logic [15:0] stall_cnt, flush_cnt;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w, md_start;
  logic load_use;

  assign load_use = hz.MemReadE && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    ret_nxt     = ret_state;
    pending_nxt = done_pending;
    wd_nxt      = wd_cnt;
    err_set     = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    md_start    = 1'b0;

    unique case (state)
      RUN: begin
        if (!hz.DMemReadyM) begin
          {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
          state_nxt = MEM_WAIT;
          ret_nxt   = RUN;
        end else if (hz.PCSrcE) begin
          {flush_d, flush_e} = 2'b11;
        end else if (hz.MulDivE) begin
          md_start = 1'b1;
          {stall_f, stall_d, stall_e} = 3'b111;
          state_nxt   = MD_WAIT;
          wd_nxt      = '0;
          // A completion left over from an abandoned wait must not end the new op.
          pending_nxt = 1'b0;
        end else if (load_use) begin
          {stall_f, stall_d, flush_e} = 3'b111;
        end
      end

      MD_WAIT: begin
        if (!hz.DMemReadyM) begin
          {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
          state_nxt = MEM_WAIT;
          ret_nxt   = MD_WAIT;
          if (hz.MulDivDone) pending_nxt = 1'b1;
        end else if (hz.MulDivDone || done_pending) begin
          state_nxt   = RUN;
          pending_nxt = 1'b0;
        end else if (wd_cnt == WD_LAST) begin
          err_set   = 1'b1;
          state_nxt = RUN;
        end else begin
          {stall_f, stall_d, stall_e} = 3'b111;
          wd_nxt = wd_cnt + 6'd1;
        end
      end

      MEM_WAIT: begin
        if (hz.MulDivDone) pending_nxt = 1'b1;
        if (!hz.DMemReadyM) begin
          {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
        end else begin
          // Returning to a mul/div wait keeps the front end frozen one more cycle.
          if (ret_state == MD_WAIT) {stall_f, stall_d, stall_e} = 3'b111;
          state_nxt = ret_state;
        end
      end

      default: state_nxt = RUN;
    endcase

    if (!rst) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b0000;
      {flush_d, flush_e, flush_w, md_start} = 4'b0000;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      ret_state    <= RUN;
      done_pending <= 1'b0;
      wd_cnt       <= '0;
      md_err       <= 1'b0;
    end else begin
      state        <= state_nxt;
      ret_state    <= ret_nxt;
      done_pending <= pending_nxt;
      wd_cnt       <= wd_nxt;
      if (err_set) md_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (hz.CountClr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_e && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign hz.StallF      = stall_f;
  assign hz.StallD      = stall_d;
  assign hz.StallE      = stall_e;
  assign hz.StallM      = stall_m;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushW      = flush_w;
  assign hz.MulDivStart = md_start;
  assign hz.MulDivErr   = md_err;
  assign hz.CtrlState   = state;
  assign hz.StallCount  = stall_cnt;
  assign hz.FlushCount  = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic,
// every cycle scored against a behavioural pipeline-control model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MD_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic mem_read, pc, md, done, ready, clr;
  } in_t;

  typedef struct packed {
    logic sf, sd, se, sm, fd, fe, fw, start, err;
    logic [1:0]  st;
    logic [15:0] sc, fc;
  } exp_t;

  typedef enum {M_RUN, M_MD, M_MEM} mode_t;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t e_mon;

  // Reference model: what the pipeline is doing, not how the RTL encodes it.
  mode_t m_mode, m_resume;
  bit    m_pending, m_err;
  int    m_md_cycles, m_sc, m_fc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t actual();
    exp_t a;
    a = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE,
         hif.FlushW, hif.MulDivStart, hif.MulDivErr, hif.CtrlState,
         hif.StallCount, hif.FlushCount};
    return a;
  endfunction

  task automatic model_reset();
    m_mode = M_RUN; m_resume = M_RUN; m_pending = 0; m_err = 0;
    m_md_cycles = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_cycle(input in_t s, output exp_t e);
    bit    hazard;
    mode_t nxt;
    e     = '0;
    e.st  = (m_mode == M_RUN) ? 2'b00 : (m_mode == M_MD) ? 2'b01 : 2'b10;
    e.err = m_err;
    e.sc  = 16'(m_sc);
    e.fc  = 16'(m_fc);
    hazard = s.mem_read && (s.rd != 0) && ((s.rd == s.rs1) || (s.rd == s.rs2));
    nxt = m_mode;
    if (!s.ready) begin
      {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
      if (m_mode != M_MEM) begin m_resume = m_mode; nxt = M_MEM; end
      if (m_mode != M_RUN && s.done) m_pending = 1;
    end else begin
      case (m_mode)
        M_RUN: begin
          if (s.pc) {e.fd, e.fe} = 2'b11;
          else if (s.md) begin
            e.start = 1; {e.sf, e.sd, e.se} = 3'b111;
            nxt = M_MD; m_md_cycles = 0; m_pending = 0;
          end else if (hazard) {e.sf, e.sd, e.fe} = 3'b111;
        end
        M_MD: begin
          m_md_cycles++;
          if (s.done || m_pending) begin nxt = M_RUN; m_pending = 0; end
          else if (m_md_cycles == TO) begin m_err = 1; nxt = M_RUN; end
          else {e.sf, e.sd, e.se} = 3'b111;
        end
        default: begin
          if (s.done) m_pending = 1;
          if (m_resume == M_MD) {e.sf, e.sd, e.se} = 3'b111;
          nxt = m_resume;
        end
      endcase
    end
    if (s.clr) begin m_sc = 0; m_fc = 0; end
    else begin
      if (e.sf && m_sc < 65535) m_sc++;
      if (e.fe && m_fc < 65535) m_fc++;
    end
    m_mode = nxt;
  endtask

  function automatic in_t idle();
    in_t s = '0;
    s.ready = 1'b1;
    return s;
  endfunction

  function automatic in_t rand_in();
    in_t s;
    s.rs1 = 5'($urandom_range(0, 3));
    s.rs2 = 5'($urandom_range(0, 3));
    s.rd  = 5'($urandom_range(0, 3));
    s.mem_read = ($urandom_range(0, 99) < 30);
    s.pc    = ($urandom_range(0, 99) < 12);
    s.md    = ($urandom_range(0, 99) < 10);
    s.done  = ($urandom_range(0, 99) < 15);
    s.ready = ($urandom_range(0, 99) < 85);
    s.clr   = ($urandom_range(0, 99) < 2);
    return s;
  endfunction

  task automatic drive(input in_t s);
    hif.Rs1D = s.rs1; hif.Rs2D = s.rs2; hif.RdE = s.rd;
    hif.MemReadE = s.mem_read; hif.PCSrcE = s.pc; hif.MulDivE = s.md;
    hif.MulDivDone = s.done; hif.DMemReadyM = s.ready; hif.CountClr = s.clr;
  endtask

  task automatic step(input in_t s);
    exp_t e;
    @(posedge clk); #1;
    drive(s);
    model_cycle(s, e);
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    drive(idle());
    model_reset();
    #1;
    check("reset_all_zero", 64'(actual()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents outputs, score them against the queue.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      check("cycle_outputs", 64'(actual()), 64'(e_mon));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    in_t s;
    model_reset();
    drive(idle());
    #3;
    check("reset_state", 64'(actual()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Load-use: exactly one bubble, one flush counted.
    s = idle(); s.mem_read = 1; s.rd = 5'd5; s.rs2 = 5'd5;
    step(s); @(negedge clk);
    check("loaduse_bubble", {hif.StallF, hif.StallD, hif.FlushE}, 3'b111);
    step(idle()); @(negedge clk);
    check("loaduse_released", {hif.StallF, hif.StallD, hif.FlushE}, 3'b000);
    check("loaduse_flushcount", hif.FlushCount, 16'd1);

    // Branch wins over load-use.
    s = idle(); s.pc = 1; s.mem_read = 1; s.rd = 5'd7; s.rs1 = 5'd7;
    step(s); @(negedge clk);
    check("branch_over_loaduse", {hif.FlushD, hif.FlushE, hif.StallF, hif.StallD}, 4'b1100);

    // Mul/div with done four cycles after start.
    s = idle(); s.md = 1;
    step(s); @(negedge clk);
    check("md_start", {hif.MulDivStart, hif.StallF, hif.StallD, hif.StallE, hif.CtrlState}, 6'b111100);
    for (int i = 0; i < 3; i++) begin
      step(idle()); @(negedge clk);
      check("md_wait", {hif.MulDivStart, hif.StallF, hif.StallD, hif.StallE, hif.CtrlState}, 6'b011101);
    end
    s = idle(); s.done = 1;
    step(s); @(negedge clk);
    check("md_done", {hif.StallF, hif.StallD, hif.StallE, hif.CtrlState}, 5'b00001);
    step(idle()); @(negedge clk);
    check("md_back_run", hif.CtrlState, 2'b00);

    // Memory wait interrupting mul/div, with done arriving during the wait.
    s = idle(); s.md = 1;
    step(s);
    s = idle(); s.ready = 0;
    step(s); @(negedge clk);
    check("mdmem_enter", {hif.CtrlState, hif.StallM, hif.FlushW}, 4'b0111);
    s.done = 1;
    step(s); @(negedge clk);
    check("mdmem_wait", {hif.CtrlState, hif.MulDivStart}, 3'b100);
    s.done = 0;
    step(s);
    step(idle()); @(negedge clk);
    check("mdmem_release", {hif.CtrlState, hif.StallF, hif.StallE, hif.StallM}, 5'b10110);
    step(idle()); @(negedge clk);
    check("mdmem_pending_used", {hif.CtrlState, hif.StallF, hif.MulDivStart}, 4'b0100);
    step(idle()); @(negedge clk);
    check("mdmem_run", {hif.CtrlState, hif.MulDivStart}, 3'b000);

    // Watchdog abort after TO wait cycles; error is sticky.
    s = idle(); s.md = 1;
    step(s);
    for (int i = 0; i < TO - 1; i++) step(idle());
    @(negedge clk);
    check("wd_last_stall", {hif.StallF, hif.MulDivErr, hif.CtrlState}, 4'b1001);
    step(idle()); @(negedge clk);
    check("wd_abort_cycle", {hif.StallF, hif.MulDivErr, hif.CtrlState}, 4'b0001);
    step(idle()); @(negedge clk);
    check("wd_err_set", {hif.MulDivErr, hif.CtrlState}, 3'b100);
    repeat (5) step(idle());
    @(negedge clk);
    check("wd_err_sticky", hif.MulDivErr, 1'b1);
    apply_reset();

    // Stall counter saturation, then clear.
    s = idle(); s.ready = 0;
    for (int i = 0; i < 65534; i++) step(s);
    step(s); @(negedge clk);
    check("stallcnt_fffe", hif.StallCount, 16'hFFFE);
    step(s); step(s);
    step(idle()); @(negedge clk);
    check("stallcnt_sat", hif.StallCount, 16'hFFFF);
    step(idle()); @(negedge clk);
    check("stallcnt_hold", hif.StallCount, 16'hFFFF);
    s = idle(); s.clr = 1; s.ready = 0;
    step(s);
    step(idle()); step(idle()); @(negedge clk);
    check("clr_wins", hif.StallCount, 16'd0);

    // Reset in the middle of a mul/div wait.
    s = idle(); s.md = 1;
    step(s);
    step(idle()); @(negedge clk);
    check("pre_reset_busy", {hif.StallF, hif.CtrlState}, 3'b101);
    apply_reset();
    s = idle(); s.mem_read = 1; s.rd = 5'd3; s.rs1 = 5'd3;
    step(s); @(negedge clk);
    check("post_reset_run", {hif.CtrlState, hif.StallF, hif.FlushE, hif.StallE}, 5'b00110);

    // Random traffic scored by the monitor, with one reset in the middle.
    for (int i = 0; i < 1500; i++) step(rand_in());
    apply_reset();
    for (int i = 0; i < 1500; i++) step(rand_in());

    step(idle());
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, 0 required", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MD_TIMEOUT, 40, max MD_WAIT cycles before watchdog abort (range 2..63).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 Rs1D, Rs2D  in  5 each  source registers of instruction in Decode.
REQ-005 RdE  in  5  destination register of instruction in Execute.
REQ-006 MemReadE  in  1  instruction in Execute is a load.
REQ-007 PCSrcE  in  1  taken branch/jump resolved in Execute.
REQ-008 MulDivE  in  1  instruction in Execute is a multicycle mul/div.
REQ-009 MulDivDone  in  1  multicycle unit result valid (single-cycle pulse).
REQ-010 DMemReadyM  in  1  data memory completes the Memory-stage access this cycle.
REQ-011 CountClr  in  1  synchronous clear of performance counters.
REQ-012 StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
REQ-013 FlushD, FlushE, FlushW  out  1 each  zero the IF/ID, ID/EX, MEM/WB register on the next edge.
REQ-014 MulDivStart  out  1  one-cycle start pulse to the multicycle unit.
REQ-015 MulDivErr  out  1  sticky watchdog error.
REQ-016 CtrlState  out  2  current state: RUN=00, MD_WAIT=01, MEM_WAIT=10.
REQ-017 StallCount, FlushCount  out  16 each  saturating performance counters.

Function
REQ-018 Stall/flush/MulDivStart outputs SHALL be combinational from state plus current inputs (zero-cycle latency); all other outputs registered.
REQ-019 Load-use hazard = MemReadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-020 Priority, highest first: memory wait, PCSrcE, MulDivE, load-use.
REQ-021 RUN, DMemReadyM=0: StallF/D/E/M=1, FlushW=1, all other outputs 0; next=MEM_WAIT, return state=RUN.
REQ-022 RUN, PCSrcE=1: FlushD=FlushE=1, no stalls, load-use ignored; stay RUN.
REQ-023 RUN, MulDivE=1: MulDivStart=1, StallF/D/E=1, FlushE=0; next=MD_WAIT, watchdog counter=0.
REQ-024 RUN, load-use only: StallF=StallD=1, FlushE=1; stay RUN (exactly one bubble).
REQ-025 MD_WAIT: StallF/D/E=1 each cycle; watchdog counter increments.
REQ-026 MD_WAIT with MulDivDone=1 (or done_pending set): stalls deassert that cycle, next=RUN, done_pending cleared.
REQ-027 MD_WAIT, watchdog reaches MD_TIMEOUT without done: MulDivErr<=1, stalls deassert that cycle, next=RUN.
REQ-028 MD_WAIT, DMemReadyM=0: memory wait takes precedence (REQ-021 outputs); next=MEM_WAIT, return state=MD_WAIT; watchdog holds.
REQ-029 MEM_WAIT: StallF/D/E/M=1, FlushW=1 while DMemReadyM=0; FlushD/FlushE SHALL be 0 (branch in Execute held and flushes after release).
REQ-030 MEM_WAIT, DMemReadyM=1: stalls deassert unless return state is MD_WAIT (then StallF/D/E stay 1); next=return state.
REQ-031 MulDivDone arriving in MEM_WAIT SHALL set done_pending; MulDivDone outside MD_WAIT/MEM_WAIT is ignored.
REQ-032 MulDivStart SHALL never assert in MD_WAIT or MEM_WAIT.
REQ-033 StallCount +1 each cycle StallF=1; FlushCount +1 each cycle FlushE=1; both saturate at 0xFFFF.
REQ-034 CountClr=1 zeroes both counters that edge; clear wins over increment.

Reset
REQ-035 rst low SHALL immediately force state=RUN, return state=RUN, done_pending=0, watchdog=0, MulDivErr=0, both counters=0, and all stall/flush/MulDivStart outputs 0.
REQ-036 Reset mid MD_WAIT/MEM_WAIT SHALL abandon the operation; first cycle after release behaves as RUN.

Verification
REQ-037 Load-use: MemReadE=1, RdE=5, Rs2D=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle; FlushCount=1.
REQ-038 Branch + load-use same cycle: PCSrcE=1, load-use true -> FlushD=FlushE=1, StallF=StallD=0.
REQ-039 MulDivE=1, MulDivDone 4 cycles later -> MulDivStart one cycle, StallF/D/E=1 for 4 cycles, CtrlState 00->01->00.
REQ-040 MD_WAIT, DMemReadyM=0 for 3 cycles with MulDivDone during the wait -> CtrlState 01->10->01->00, done consumed, no second MulDivStart.
REQ-041 MulDivE with no MulDivDone, MD_TIMEOUT=40 -> MulDivErr=1 after 40 MD_WAIT cycles, state RUN, error holds until rst.
REQ-042 StallCount preloaded to 0xFFFE, 3 stall cycles -> reads 0xFFFF; CountClr -> 0; rst asserted mid MD_WAIT -> all outputs 0 immediately.
